// File: rtl/fd_inst_queue_pkg.sv
// ============================================================================
// Module : fd_inst_queue_pkg
// Brief  : Shared constants and entry type for the fetch/decode queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fd_inst_queue_pkg;

   localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
   localparam logic [4:0]  C_EXC_ADEL = 5'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fdq_entry_t;

   function automatic logic [4:0] exccode_of(input logic adel);
      return adel ? C_EXC_ADEL : 5'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fdq_store.sv
// ============================================================================
// Module : fdq_store
// Brief  : DEPTH-entry queue storage, one synchronous write port and one
//          asynchronous read port. Contents are deliberately not reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fdq_store
   import fd_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  fdq_entry_t                 wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output fdq_entry_t                 rd_data
);

   fdq_entry_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fd_inst_queue.sv
// ============================================================================
// Module : fd_inst_queue
// Brief  : Fetch-to-decode instruction queue with flush and AdEL tagging.
// Config : FDQ_BYPASS_EN - forward fetch word straight to decode when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fd_inst_queue
   import fd_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = C_RESET_PC
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     f_valid,
   output logic                     f_ready,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_instr,
   input  logic                     f_adel,
   input  logic                     flush,
   output logic                     d_valid,
   input  logic                     d_ready,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_instr,
   output logic [4:0]               d_exccode,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned         AW     = $clog2(DEPTH);
   localparam int unsigned         CW     = AW + 1;
   localparam logic [CW-1:0]       C_FULL = CW'(DEPTH);

   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic           w_empty;
   logic           w_bypass;
   logic           w_push;
   logic           w_pop;
   fdq_entry_t     w_f_entry;
   fdq_entry_t     w_rd_entry;
   fdq_entry_t     w_head;

   assign w_f_entry = '{pc: f_pc, instr: f_instr, adel: f_adel};
   assign w_empty   = (r_count == '0);

`ifdef FDQ_BYPASS_EN
   assign w_bypass = w_empty && f_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // Full stalls fetch even if decode drains this cycle: no pop-through.
   assign f_ready = (r_count != C_FULL);
   assign d_valid = !flush && (!w_empty || w_bypass);

   // A bypassed word consumed by decode is neither stored nor popped.
   assign w_push = f_valid && f_ready && !flush && !(w_bypass && d_ready);
   assign w_pop  = d_valid && d_ready && !w_bypass;

   assign w_head = w_bypass ? w_f_entry : w_rd_entry;

   assign d_pc      = d_valid ? w_head.pc : RESET_PC;
   assign d_instr   = (d_valid && !w_head.adel) ? w_head.instr : 32'd0;
   assign d_exccode = d_valid ? exccode_of(w_head.adel) : 5'd0;
   assign count     = r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   fdq_store #(
      .DEPTH   (DEPTH)
   ) u_store (
      .clk     (clk),
      .wr_en   (w_push),
      .wr_addr (r_wr_ptr),
      .wr_data (w_f_entry),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_entry)
   );

endmodule

`default_nettype wire

// File: tb/tb_fd_inst_queue.sv
// ============================================================================
// Module : tb_fd_inst_queue
// Brief  : Self-checking bench for fd_inst_queue against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fd_inst_queue;

   localparam int          DEPTH  = 4;
   localparam int          CW     = $clog2(DEPTH) + 1;
   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic              clk     = 1'b0;
   logic              reset   = 1'b0;
   logic              f_valid = 1'b0;
   logic [31:0]       f_pc    = '0;
   logic [31:0]       f_instr = '0;
   logic              f_adel  = 1'b0;
   logic              flush   = 1'b0;
   logic              d_ready = 1'b0;
   logic              f_ready;
   logic              d_valid;
   logic [31:0]       d_pc;
   logic [31:0]       d_instr;
   logic [4:0]        d_exccode;
   logic [CW-1:0]     count;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } ent_t;

   ent_t q[$];

   logic          e_valid;
   logic          e_ready;
   logic [31:0]   e_pc;
   logic [31:0]   e_instr;
   logic [4:0]    e_exc;
   logic [CW-1:0] e_count;

   always #5 clk = ~clk;

   fd_inst_queue #(
      .DEPTH     (DEPTH),
      .RESET_PC  (RST_PC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_pc      (f_pc),
      .f_instr   (f_instr),
      .f_adel    (f_adel),
      .flush     (flush),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_pc      (d_pc),
      .d_instr   (d_instr),
      .d_exccode (d_exccode),
      .count     (count)
   );

`ifdef FDQ_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Expected decode-side view for the current inputs and held entries.
   task automatic model_expect();
      ent_t h;
      bit   byp;
      byp     = BYPASS && (q.size() == 0) && f_valid;
      e_valid = !flush && ((q.size() > 0) || byp);
      h       = (q.size() > 0) ? q[0] : '{pc: f_pc, instr: f_instr, adel: f_adel};
      e_pc    = e_valid ? h.pc : RST_PC;
      e_instr = (e_valid && !h.adel) ? h.instr : 32'd0;
      e_exc   = (e_valid && h.adel) ? 5'd4 : 5'd0;
      e_count = CW'(q.size());
      e_ready = (q.size() != DEPTH);
   endtask

   task automatic model_step();
      int sz;
      sz = q.size();
      if (flush) begin
         q.delete();
      end else if (BYPASS && sz == 0 && f_valid && d_ready) begin
         // forwarded and consumed in the same cycle
      end else begin
         if (sz > 0 && d_ready) void'(q.pop_front());
         if (f_valid && sz < DEPTH) q.push_back('{pc: f_pc, instr: f_instr, adel: f_adel});
      end
   endtask

   task automatic set_in(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic adel, input logic dr, input logic fl);
      f_valid = fv; f_pc = pc; f_instr = ins; f_adel = adel; d_ready = dr; flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      q.delete();
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      n_checks++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid got %b want 0", d_valid); else n_pass++;
      n_checks++; if (f_ready !== 1'b1) $display("FAIL reset_f_ready got %b want 1", f_ready); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_checks++; if (d_pc !== RST_PC) $display("FAIL reset_d_pc got %h want %h", d_pc, RST_PC); else n_pass++;
      n_checks++; if (d_instr !== 32'd0) $display("FAIL reset_d_instr got %h want 0", d_instr); else n_pass++;
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL reset_d_exccode got %0d want 0", d_exccode); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      q.delete();
   endtask

   task automatic test_reset_midstream();
      do_reset();
      set_in(1, 32'h3000, 32'h11, 0, 0, 0); tick();
      set_in(1, 32'h3004, 32'h22, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (count !== CW'(2)) $display("FAIL mid_pre_count got %0d want 2", count); else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (d_valid !== 1'b0) $display("FAIL mid_rst_d_valid got %b want 0", d_valid); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL mid_rst_count got %0d want 0", count); else n_pass++;
      n_checks++; if (d_pc !== RST_PC) $display("FAIL mid_rst_d_pc got %h want %h", d_pc, RST_PC); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      q.delete();
      tick();
      n_checks++; if (d_valid !== 1'b0) $display("FAIL mid_rel_d_valid got %b want 0", d_valid); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL mid_rel_count got %0d want 0", count); else n_pass++;
   endtask

   task automatic test_fill();
      logic [31:0] pc;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         pc = 32'h3000 + 32'(4 * i);
         set_in(1, pc, pc ^ 32'hA5A5_0000, 0, 0, 0);
         n_checks++;
         if (f_ready !== (i < 4)) $display("FAIL fill_f_ready[%0d] got %b want %b", i, f_ready, (i < 4));
         else n_pass++;
         tick();
      end
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (count !== CW'(4)) $display("FAIL fill_count got %0d want 4", count); else n_pass++;
      n_checks++; if (f_ready !== 1'b0) $display("FAIL fill_f_ready_full got %b want 0", f_ready); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h3000 + 32'(4 * i);
         set_in(0, 0, 0, 0, 1, 0);
         n_checks++;
         if (d_pc !== pc || d_valid !== 1'b1) $display("FAIL fill_drain[%0d] got %h/%b want %h/1", i, d_pc, d_valid, pc);
         else n_pass++;
         tick();
      end
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (d_valid !== 1'b0) $display("FAIL fill_fifth_dropped got d_valid %b want 0", d_valid); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] pc;
      do_reset();
      set_in(1, 32'h3000, 32'h100, 0, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         pc = 32'h3004 + 32'(4 * i);
         set_in(1, pc, 32'h100 + 32'(i + 1), 0, 1, 0);
         pc = 32'h3000 + 32'(4 * i);
         n_checks++;
         if (d_pc !== pc || d_instr !== 32'h100 + 32'(i)) $display("FAIL wrap_pc[%0d] got %h/%h want %h/%h", i, d_pc, d_instr, pc, 32'h100 + 32'(i));
         else n_pass++;
         n_checks++;
         if (count !== CW'(1)) $display("FAIL wrap_count[%0d] got %0d want 1", i, count);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h3000 + 32'(4 * i), 32'h55, 0, 0, 0); tick();
      end
      set_in(1, 32'h4000, 32'h66, 0, 1, 1);
      n_checks++; if (d_valid !== 1'b0) $display("FAIL flush_d_valid got %b want 0", d_valid); else n_pass++;
      n_checks++; if (d_pc !== RST_PC) $display("FAIL flush_d_pc got %h want %h", d_pc, RST_PC); else n_pass++;
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (count !== '0) $display("FAIL flush_count got %0d want 0", count); else n_pass++;
      n_checks++; if (d_valid !== 1'b0) $display("FAIL flush_word_lost got d_valid %b want 0", d_valid); else n_pass++;
   endtask

   task automatic test_fault();
      do_reset();
      set_in(1, 32'h0000_2ffc, 32'h1234_5678, 1, 0, 0); tick();
      set_in(1, 32'h0000_3000, 32'h0000_0abc, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (d_pc !== 32'h2ffc) $display("FAIL fault_d_pc got %h want 00002ffc", d_pc); else n_pass++;
      n_checks++; if (d_exccode !== 5'd4) $display("FAIL fault_exccode got %0d want 4", d_exccode); else n_pass++;
      n_checks++; if (d_instr !== 32'd0) $display("FAIL fault_instr got %h want 0", d_instr); else n_pass++;
      set_in(0, 0, 0, 0, 1, 0); tick();
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL clean_exccode got %0d want 0", d_exccode); else n_pass++;
      n_checks++; if (d_instr !== 32'h0abc) $display("FAIL clean_instr got %h want 00000abc", d_instr); else n_pass++;
   endtask

   task automatic test_bypass_latency();
      do_reset();
      set_in(1, 32'h3000, 32'h77, 0, 1, 0);
      n_checks++;
      if (d_valid !== BYPASS) $display("FAIL lat_same_cycle got d_valid %b want %b", d_valid, BYPASS);
      else n_pass++;
      if (BYPASS) begin
         n_checks++; if (d_pc !== 32'h3000) $display("FAIL lat_bypass_pc got %h want 00003000", d_pc); else n_pass++;
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (count !== (BYPASS ? CW'(0) : CW'(1))) $display("FAIL lat_count got %0d want %0d", count, BYPASS ? 0 : 1);
      else n_pass++;
      n_checks++;
      if (d_valid !== !BYPASS) $display("FAIL lat_next_cycle got d_valid %b want %b", d_valid, !BYPASS);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
         model_expect();
         n_checks++; if (d_valid !== e_valid) $display("FAIL rnd_d_valid[%0d] got %b want %b", i, d_valid, e_valid); else n_pass++;
         n_checks++; if (f_ready !== e_ready) $display("FAIL rnd_f_ready[%0d] got %b want %b", i, f_ready, e_ready); else n_pass++;
         n_checks++; if (count !== e_count) $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, e_count); else n_pass++;
         n_checks++; if (d_pc !== e_pc) $display("FAIL rnd_d_pc[%0d] got %h want %h", i, d_pc, e_pc); else n_pass++;
         n_checks++; if (d_instr !== e_instr) $display("FAIL rnd_d_instr[%0d] got %h want %h", i, d_instr, e_instr); else n_pass++;
         n_checks++; if (d_exccode !== e_exc) $display("FAIL rnd_d_exccode[%0d] got %0d want %0d", i, d_exccode, e_exc); else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_fill();
      test_wrap();
      test_flush();
      test_fault();
      test_bypass_latency();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fd_inst_queue.md
FD_INST_QUEUE -- requirements
Module: fd_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00003000, PC value reported on d_pc while empty.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port f_valid  input  1  fetch presents an instruction this cycle.
REQ-006 SHALL have port f_ready  output  1  queue accepts the fetch word this cycle.
REQ-007 SHALL have port f_pc  input  32  fetch PC.
REQ-008 SHALL have port f_instr  input  32  fetched word (already 0 on fetch fault).
REQ-009 SHALL have port f_adel  input  1  fetch address-error flag.
REQ-010 SHALL have port flush  input  1  discard all held and incoming entries (exception/eret redirect).
REQ-011 SHALL have port d_valid  output  1  decode-side head entry valid.
REQ-012 SHALL have port d_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port d_pc  output  32  head PC.
REQ-014 SHALL have port d_instr  output  32  head instruction.
REQ-015 SHALL have port d_exccode  output  5  5'd4 (AdEL) if head faulted, else 5'd0.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL push when f_valid && f_ready && !flush; pop when d_valid && d_ready && !flush.
REQ-018 SHALL drive f_ready = (count != DEPTH), independent of d_ready (no pop-through when full).
REQ-019 SHALL keep count unchanged on simultaneous push and pop; +1 push only, -1 pop only.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; FIFO order preserved across wrap.
REQ-021 SHALL, in the flush cycle, drive d_valid=0, ignore f_valid, and on the next edge set count=0, pointers=0.
REQ-022 SHALL, when d_valid=0, drive d_pc=RESET_PC, d_instr=0, d_exccode=0.
REQ-023 SHALL force d_instr=0 whenever head carries f_adel=1, regardless of stored word.
REQ-024 SHALL present stored data with 1-cycle latency (push at edge N visible after edge N) when bypass disabled.
REQ-025 SHALL hold head outputs stable while d_valid && !d_ready (no mutation of held entry).

Reset
REQ-026 SHALL, on reset low, asynchronously clear count, pointers; outputs d_valid=0, f_ready=1, count=0, d_pc=RESET_PC, d_instr=0, d_exccode=0.
REQ-027 SHALL, on reset asserted mid-operation, drop all entries; no entry reappears after release.
REQ-028 SHALL NOT require storage array contents to be reset.

Configuration
REQ-029 SHALL, with macro FDQ_BYPASS_EN defined, when count==0 and !flush, drive d_valid=f_valid and d_pc/d_instr/d_exccode from f_* combinationally; if d_ready also high the word is not stored.
REQ-030 SHALL, without FDQ_BYPASS_EN, never forward f_* combinationally; minimum latency 1 cycle.

Structure
REQ-031 SHALL take RESET_PC default and exccode constant ADEL=5'd4 from the shared constants package const.
REQ-032 SHALL place entry storage (DEPTH x {pc, instr, adel}, write port, async read port) in sub-module fdq_store.
REQ-033 SHALL keep pointer/count/handshake logic in fd_inst_queue only.

Verification
REQ-034 SHALL cover reset: reset low mid-stream -> d_valid=0, count=0, d_pc=32'h00003000 immediately, before clk edge.
REQ-035 SHALL cover fill: 5 pushes of pc 3000,3004,...,3010 with d_ready=0, DEPTH=4 -> f_ready=0 after 4th, 5th not stored, count=4.
REQ-036 SHALL cover wrap: continuous push+pop for 10 cycles -> d_pc sequence 3000..3024 in order, count constant.
REQ-037 SHALL cover flush: count=3, flush=1 with f_valid=1 -> d_valid=0 that cycle, count=0 next cycle, pushed word lost.
REQ-038 SHALL cover fault: push f_pc=32'h00002ffc, f_adel=1, f_instr=32'h12345678 -> d_exccode=5'd4, d_instr=0.
REQ-039 SHALL cover bypass: FDQ_BYPASS_EN, empty, f_valid=1, d_ready=1, f_pc=32'h3000 -> d_valid=1, d_pc=32'h3000 same cycle, count stays 0; without macro d_valid rises one cycle later.
